change_return_controller: RTL and testbench
===========================================

# change_return_controller

Parametrised successor to the single-shot coin-return timer of the vending machine. Tracks customer inactivity with a reloadable countdown. On timeout or an explicit return request, it latches the outstanding balance and pays it out as a greedy sequence of one-hot coin pulses, one coin per handshake. It sits between the balance keeper (which supplies `i_balance` and subtracts `o_paid_value`) and the coin-dispensing mechanism.

## Interface
- `NUM_COINS`, 3, number of coin denominations (≥1)
- `BALANCE_W`, 16, width of balance and coin values
- `COIN_VALUES`, {16'd1000,16'd500,16'd100}, packed `NUM_COINS*BALANCE_W`; index 0 is the LSB slice; strictly ascending with index; all nonzero
- `TIMEOUT`, 10, inactivity cycles before automatic return (≥1)
- `TIMER_W`, 8, width of `o_wait_time`; 2^TIMER_W > TIMEOUT
- `clk` in 1: single clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `i_input_coin` in NUM_COINS: one-hot, 1-cycle pulse per inserted coin
- `i_select_item` in 1: 1-cycle pulse on item purchase
- `i_trigger_return` in 1: 1-cycle return request
- `i_balance` in BALANCE_W: current machine balance; sampled only at return start
- `i_return_ready` in 1: dispenser accepts the presented coin this cycle
- `o_return_coin` out NUM_COINS: one-hot coin being presented; 0 when none
- `o_paid_value` out BALANCE_W: value of the coin accepted this cycle, else 0
- `o_return_busy` out 1: high in RETURN; upstream must reject coins and selections
- `o_return_done` out 1: 1-cycle pulse at end of a payout
- `o_residue` out BALANCE_W: unpayable remainder of the last payout
- `o_wait_time` out TIMER_W: countdown value

## Operation
- States: IDLE, RETURN, DONE.
- **IDLE**
  - `i_input_coin`≠0 or `i_select_item` reloads `o_wait_time` to TIMEOUT.
  - Otherwise `o_wait_time` decrements while >0.
  - Start condition: `i_trigger_return`, or `o_wait_time` making the 1→0 transition. A timer already at 0 never re-fires.
  - On start: latch `remaining` ← `i_balance`, force `o_wait_time` to 0, go to RETURN. If `i_balance` == 0 or `i_balance` < the smallest coin value, go directly to DONE instead.
  - Coin/select and trigger in the same cycle: trigger wins and there is no reload. Coin/select in the 1→0 cycle: the reload wins and there is no timeout.
- **RETURN**
  - `o_return_coin` is the one-hot of the highest index k with `COIN_VALUES[k]` ≤ `remaining`.
  - When `i_return_ready`=1: `remaining` −= `COIN_VALUES[k]`, and `o_paid_value` = `COIN_VALUES[k]` in that cycle.
  - When `remaining` < the smallest coin value after a subtraction, go to DONE.
  - `o_return_coin` must hold stable while `i_return_ready`=0.
  - `i_trigger_return`, `i_input_coin`, and `i_select_item` are ignored.
- **DONE**
  - `o_return_done`=1 and `o_residue` ← `remaining`; go to IDLE next cycle.
  - `o_residue` holds until the next DONE.
- Arithmetic: subtraction is unsigned at BALANCE_W and never underflows, because the greedy pick guarantees value ≤ `remaining`.
- Reset, asynchronous and at any time including mid-payout:
  - state IDLE;
  - all outputs 0;
  - `remaining`=0;
  - `o_wait_time`=0;
  - the partially paid balance is not resumed.

## Timing
- Trigger sampled at edge N: RETURN from N, with the first coin on `o_return_coin` in cycle N+1.
- With `i_return_ready` held high, one coin is paid per cycle. DONE is the cycle after the last accepted coin, and IDLE follows the cycle after that.
- Timeout: with the last activity sampled at edge 0, `o_wait_time`=TIMEOUT after edge 0 and reaches 0 after edge TIMEOUT; RETURN follows one edge later.
- `o_return_coin` and `o_return_busy` are driven from registers plus greedy decode of registered `remaining`, with no combinational path from inputs. `o_paid_value` depends combinationally on `i_return_ready`.

## Structure
- The shared defines header holds:
  - state encoding;
  - default `COIN_VALUES`, `NUM_COINS`, and `TIMEOUT`, replacing `kNumCoins`/`kNumItems` usage for this block.
- Sub-module `greedy_coin_select`: purely combinational; inputs `remaining` and `COIN_VALUES`; outputs are the one-hot pick, its value, and a `none` flag. Reusable by the change calculator.

## Test plan
- Balance 1600, trigger at cycle 5, ready=1 → `o_return_coin` 100, 010, 001 on cycles 6, 7, 8; `o_paid_value` 1000, 500, 100; `o_return_done` at cycle 9; residue 0.
- Coin pulse at cycle 0 with balance 700, no further activity → `o_wait_time` 10→0 by edge 10; coins 010, 001, 001 starting cycle 12; done; no second return afterwards.
- Balance 1500, ready low for 3 cycles on the first coin → 100 held stable for 4 cycles; payout completes with 1000 then 500.
- Balance 150, trigger → exactly one 001 pulse; `o_residue`=50. Balance 40, trigger → DONE next cycle, no coins, residue 40.
- Trigger and coin pulse in the same cycle → return starts and the timer is 0. Coin pulse on the 1→0 cycle → timer reloads to 10 and there is no return.
- `reset_n` low for 1 cycle mid-payout of 1600 after the first coin → all outputs 0 immediately; IDLE; no further coins until a new trigger.

Source files
------------

// File: rtl/change_return_controller_pkg.sv
// Shared definitions for the change-return controller.
// Holds the state encoding and default coin/timeout configuration.
package change_return_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RETURN,
        ST_DONE
    } state_e;

    localparam int DEF_NUM_COINS = 3;
    localparam int DEF_BALANCE_W = 16;
    localparam int DEF_TIMEOUT   = 10;
    localparam int DEF_TIMER_W   = 8;

    // Index 0 is the smallest denomination.
    localparam logic [DEF_NUM_COINS*DEF_BALANCE_W-1:0] DEF_COIN_VALUES =
        {16'd1000, 16'd500, 16'd100};

endpackage

// File: rtl/change_return_controller_greedy_coin_select.sv
// Combinational greedy pick: largest coin not exceeding the remainder.
// Reusable by any block that needs to break a value into coins.
module greedy_coin_select #(
    parameter int NUM_COINS = 3,
    parameter int BALANCE_W = 16
) (
    input  logic [BALANCE_W-1:0]           remaining_i,
    input  logic [NUM_COINS*BALANCE_W-1:0] coin_values_i,
    output logic [NUM_COINS-1:0]           pick_o,
    output logic [BALANCE_W-1:0]           value_o,
    output logic                           none_o
);

    // Values ascend with index, so the last fitting coin is the largest.
    always_comb begin
        pick_o  = '0;
        value_o = '0;
        none_o  = 1'b1;
        for (int k = 0; k < NUM_COINS; k++) begin
            if (coin_values_i[k*BALANCE_W +: BALANCE_W] <= remaining_i) begin
                pick_o    = '0;
                pick_o[k] = 1'b1;
                value_o   = coin_values_i[k*BALANCE_W +: BALANCE_W];
                none_o    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/change_return_controller.sv
// Inactivity timer plus greedy coin payout of the outstanding balance.
// One coin is presented at a time and retired on each ready handshake.
module change_return_controller
    import change_return_controller_pkg::*;
#(
    parameter int NUM_COINS = DEF_NUM_COINS,
    parameter int BALANCE_W = DEF_BALANCE_W,
    parameter logic [NUM_COINS*BALANCE_W-1:0] COIN_VALUES = DEF_COIN_VALUES,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int TIMER_W   = DEF_TIMER_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_COINS-1:0] i_input_coin,
    input  logic                 i_select_item,
    input  logic                 i_trigger_return,
    input  logic [BALANCE_W-1:0] i_balance,
    input  logic                 i_return_ready,
    output logic [NUM_COINS-1:0] o_return_coin,
    output logic [BALANCE_W-1:0] o_paid_value,
    output logic                 o_return_busy,
    output logic                 o_return_done,
    output logic [BALANCE_W-1:0] o_residue,
    output logic [TIMER_W-1:0]   o_wait_time
);

    localparam logic [BALANCE_W-1:0] MIN_COIN = COIN_VALUES[BALANCE_W-1:0];

    state_e               state_q;
    logic [BALANCE_W-1:0] remaining_q;
    logic [BALANCE_W-1:0] residue_q;
    logic [TIMER_W-1:0]   wait_q;
    logic                 expire_q;

    logic [NUM_COINS-1:0] pick;
    logic [BALANCE_W-1:0] pick_value;
    logic                 pick_none;
    logic [BALANCE_W-1:0] rem_after;
    logic                 activity;
    logic                 start;

    greedy_coin_select #(
        .NUM_COINS(NUM_COINS),
        .BALANCE_W(BALANCE_W)
    ) u_select (
        .remaining_i  (remaining_q),
        .coin_values_i(COIN_VALUES),
        .pick_o       (pick),
        .value_o      (pick_value),
        .none_o       (pick_none)
    );

    assign activity  = (|i_input_coin) | i_select_item;
    assign start     = i_trigger_return | expire_q;
    assign rem_after = remaining_q - pick_value;

    // expire_q marks the edge after the countdown reached zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            residue_q   <= '0;
            wait_q      <= '0;
            expire_q    <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        expire_q    <= 1'b0;
                        wait_q      <= '0;
                        remaining_q <= i_balance;
                        if (i_balance < MIN_COIN) begin
                            residue_q <= i_balance;
                            state_q   <= ST_DONE;
                        end else begin
                            state_q   <= ST_RETURN;
                        end
                    end else if (activity) begin
                        wait_q   <= TIMER_W'(TIMEOUT);
                        expire_q <= 1'b0;
                    end else if (wait_q != '0) begin
                        wait_q   <= wait_q - TIMER_W'(1);
                        expire_q <= (wait_q == TIMER_W'(1));
                    end else begin
                        expire_q <= 1'b0;
                    end
                end
                ST_RETURN: begin
                    if (i_return_ready && !pick_none) begin
                        remaining_q <= rem_after;
                        if (rem_after < MIN_COIN) begin
                            residue_q <= rem_after;
                            state_q   <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_return_busy = (state_q == ST_RETURN);
    assign o_return_done = (state_q == ST_DONE);
    assign o_return_coin = o_return_busy ? pick : '0;
    assign o_paid_value  = (o_return_busy && i_return_ready && !pick_none)
                           ? pick_value : '0;
    assign o_residue     = residue_q;
    assign o_wait_time   = wait_q;

endmodule

// File: tb/tb_change_return_controller.sv
// Randomised and directed bench for change_return_controller.
// Expected outputs come from a greedy-division payout model.
module tb_change_return_controller;

    localparam int NC = 3;
    localparam int BW = 16;
    localparam int TO = 10;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NC-1:0] coin_in = '0;
    logic          sel = 1'b0;
    logic          trig = 1'b0;
    logic [BW-1:0] bal = '0;
    logic          rdy = 1'b0;
    logic [NC-1:0] ret_coin;
    logic [BW-1:0] paid;
    logic          busy;
    logic          done;
    logic [BW-1:0] residue;
    logic [TW-1:0] wait_t;

    int checks = 0;
    int failures = 0;

    int val[NC] = '{100, 500, 1000};

    // Model: mode 0 idle, 1 paying, 2 done.
    int m_mode = 0;
    int m_wait = 0;
    bit m_fire = 1'b0;
    int m_q[$];
    int m_residue = 0;
    int m_pend = 0;

    change_return_controller #(
        .NUM_COINS(NC),
        .BALANCE_W(BW),
        .COIN_VALUES({16'd1000, 16'd500, 16'd100}),
        .TIMEOUT(TO),
        .TIMER_W(TW)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_input_coin    (coin_in),
        .i_select_item   (sel),
        .i_trigger_return(trig),
        .i_balance       (bal),
        .i_return_ready  (rdy),
        .o_return_coin   (ret_coin),
        .o_paid_value    (paid),
        .o_return_busy   (busy),
        .o_return_done   (done),
        .o_residue       (residue),
        .o_wait_time     (wait_t)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_wait = 0;
        m_fire = 1'b0;
        m_q.delete();
        m_residue = 0;
        m_pend = 0;
    endtask

    task automatic compare();
        int ec;
        int ep;
        ec = (m_mode == 1) ? (1 << m_q[0]) : 0;
        ep = (m_mode == 1 && rdy) ? val[m_q[0]] : 0;
        check("coin", 32'(ret_coin), 32'(ec));
        check("paid", 32'(paid), 32'(ep));
        check("busy", 32'(busy), 32'(m_mode == 1));
        check("done", 32'(done), 32'(m_mode == 2));
        check("residue", 32'(residue), 32'(m_residue));
        check("wait", 32'(wait_t), 32'(m_wait));
    endtask

    // Advance the model across one rising edge with the current inputs.
    task automatic model_step();
        int r;
        int n;
        case (m_mode)
            0: begin
                if (trig || m_fire) begin
                    m_fire = 1'b0;
                    m_wait = 0;
                    r = int'(bal);
                    for (int k = NC - 1; k >= 0; k--) begin
                        n = r / val[k];
                        r = r % val[k];
                        repeat (n) m_q.push_back(k);
                    end
                    if (m_q.size() == 0) begin
                        m_residue = r;
                        m_mode = 2;
                    end else begin
                        m_pend = r;
                        m_mode = 1;
                    end
                end else if (coin_in != 0 || sel) begin
                    m_wait = TO;
                    m_fire = 1'b0;
                end else if (m_wait > 0) begin
                    m_fire = (m_wait == 1);
                    m_wait--;
                end else begin
                    m_fire = 1'b0;
                end
            end
            1: begin
                if (rdy) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) begin
                        m_residue = m_pend;
                        m_mode = 2;
                    end
                end
            end
            default: m_mode = 0;
        endcase
    endtask

    task automatic cyc(input logic [NC-1:0] c, input logic s, input logic t,
                       input logic [BW-1:0] b, input logic r);
        @(negedge clk);
        coin_in = c;
        sel = s;
        trig = t;
        bal = b;
        rdy = r;
        #1;
        compare();
        model_step();
    endtask

    task automatic mid_reset();
        @(negedge clk);
        coin_in = '0;
        sel = 1'b0;
        trig = 1'b0;
        rdy = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_coin", 32'(ret_coin), 32'd0);
        check("rst_paid", 32'(paid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_residue", 32'(residue), 32'd0);
        check("rst_wait", 32'(wait_t), 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int guard;
        repeat (2) @(negedge clk);
        #1;
        check("por_busy", 32'(busy), 32'd0);
        check("por_wait", 32'(wait_t), 32'd0);
        check("por_residue", 32'(residue), 32'd0);
        reset_n = 1'b1;

        // Trigger with 1600: 1000, 500, 100 then done.
        cyc('0, 0, 1, 16'd1600, 1);
        repeat (6) cyc('0, 0, 0, 16'd1600, 1);

        // Timeout payout of 700, then no second return.
        cyc(3'b001, 0, 0, 16'd700, 1);
        repeat (25) cyc('0, 0, 0, 16'd700, 1);
        check("timeout_quiet", 32'(busy), 32'd0);

        // Ready held low on the first coin.
        cyc('0, 0, 1, 16'd1500, 0);
        repeat (3) cyc('0, 0, 0, 16'd1500, 0);
        repeat (5) cyc('0, 0, 0, 16'd1500, 1);

        // 150 leaves 50; 40 goes straight to done.
        cyc('0, 0, 1, 16'd150, 1);
        repeat (4) cyc('0, 0, 0, 16'd150, 1);
        check("residue_50", 32'(residue), 32'd50);
        cyc('0, 0, 1, 16'd40, 1);
        repeat (3) cyc('0, 0, 0, 16'd40, 1);
        check("residue_40", 32'(residue), 32'd40);

        // Trigger beats a same-cycle coin.
        cyc(3'b010, 0, 1, 16'd500, 1);
        repeat (4) cyc('0, 0, 0, 16'd500, 1);

        // Coin on the 1->0 cycle reloads instead of timing out.
        cyc(3'b100, 0, 0, 16'd500, 1);
        guard = 0;
        while (m_wait != 1 && guard < 40) begin
            cyc('0, 0, 0, 16'd500, 1);
            guard++;
        end
        check("wait_reach_1", 32'(m_wait), 32'd1);
        cyc('0, 1, 0, 16'd500, 1);
        repeat (3) cyc('0, 0, 0, 16'd500, 1);

        // Reset after the first coin of 1600.
        cyc('0, 0, 1, 16'd1600, 1);
        cyc('0, 0, 0, 16'd1600, 1);
        mid_reset();
        repeat (5) cyc('0, 0, 0, 16'd1600, 1);

        // Random phase.
        for (int i = 0; i < 3000; i++) begin
            logic [NC-1:0] c;
            logic [BW-1:0] b;
            c = ($urandom_range(0, 15) == 0) ? NC'(1 << $urandom_range(0, NC - 1)) : '0;
            b = ($urandom_range(0, 3) == 0) ? BW'($urandom_range(0, 120))
                                            : BW'($urandom_range(0, 4000));
            if ($urandom_range(0, 300) == 0) begin
                mid_reset();
            end else begin
                cyc(c, $urandom_range(0, 20) == 0, $urandom_range(0, 25) == 0,
                    b, $urandom_range(0, 9) < 7);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
